// File: rtl/sync_multi.sv
`default_nettype none
// ============================================================================
// Module   : sync_multi
// Purpose  : Multi-channel input synchronizer with per-channel edge detection.
//            Each of NUM_CH asynchronous inputs passes through a STAGES-deep
//            flop chain into the clk domain. Single-cycle rise/fall pulses and
//            an any-change flag are derived from the synchronized level.
//            Per-channel reset values let active-high and active-low inputs
//            share one instance.
// Optional : SYNC_FILTER_EN - when defined, a per-channel glitch filter sits
//            between the chain output and sync_out; a new level must persist
//            FILTER_LEN cycles before it is accepted.
// Ports    : clk        in  1       system clock, rising edge
//            n_rst      in  1       synchronous active-low reset
//            async_in   in  NUM_CH  asynchronous inputs
//            sync_out   out NUM_CH  synchronized (optionally filtered) level
//            rise_pulse out NUM_CH  1-cycle pulse on sync_out 0->1
//            fall_pulse out NUM_CH  1-cycle pulse on sync_out 1->0
//            any_change out 1       OR of all rise/fall pulses
// Revision : 1.0 - initial release
// ============================================================================
module sync_multi #(
  parameter int                NUM_CH     = 4,
  parameter int                STAGES     = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL  = '0,
  parameter int                FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              any_change
);

  // Reject impossible configurations at elaboration time.
  if (NUM_CH < 1 || STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("sync_multi: needs NUM_CH>=1, STAGES>=2, FILTER_LEN>=1");
  end

  // --------------------------------------------------------------------------
  // Synchronizer chain: stage_q[0] captures the pad, the last stage is the
  // first value considered safe to use in the clk domain.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] stage_q [STAGES];
  logic [NUM_CH-1:0] w_raw;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign w_raw = stage_q[STAGES-1];

`ifdef SYNC_FILTER_EN
  // --------------------------------------------------------------------------
  // Glitch filter: cnt counts consecutive cycles in which the raw level
  // disagrees with the accepted level. Reaching FILTER_LEN accepts the new
  // level; any agreeing cycle restarts the count, so short pulses vanish.
  // --------------------------------------------------------------------------
  localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [NUM_CH-1:0] filt_q;
  logic [NUM_CH-1:0] filt_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (w_raw[i] != filt_q[i]) begin
        // ">=" rather than "==" keeps the counter from ever wrapping.
        if (cnt_q[i] >= CNT_LAST) begin
          filt_d[i] = w_raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      filt_q <= RESET_VAL;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sync_out = filt_q;
`else
  assign sync_out = w_raw;
`endif

  // --------------------------------------------------------------------------
  // Edge detection against the previous cycle's level. The delay register
  // resets to RESET_VAL alongside the chain, so reset never creates a pulse.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync_dly_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_dly_q <= RESET_VAL;
    end else begin
      sync_dly_q <= sync_out;
    end
  end

  assign rise_pulse = sync_out & ~sync_dly_q;
  assign fall_pulse = ~sync_out & sync_dly_q;
  assign any_change = |(rise_pulse | fall_pulse);

endmodule
`default_nettype wire
